// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scan driver with hex decode, per-digit decimal
// points, leading-zero blanking and a frame-synchronous pending/display buffer.
module seg_scan_driver #(
    parameter int DIGITS         = 4,
    parameter int CLK_DIV        = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic                  seg_dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [6:0]        SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic              DP_OFF   = SEG_ACTIVE_LOW;
    localparam logic [DIGITS-1:0] AN_OFF   = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic [4*DIGITS-1:0] disp_val, pend_val;
    logic [DIGITS-1:0]   disp_dp, pend_dp;
    logic                disp_blz, pend_blz, pend_valid;
    logic                wrap_q;

    logic                tc, wrap;
    logic [3:0]          nib;
    logic [DIGITS-1:0]   blank_vec;
    logic [6:0]          seg_on;
    logic                dp_on;
    logic [DIGITS-1:0]   an_on;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'h3F;
            4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;
            4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;
            4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;
            4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;
            4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;
            4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;
            4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;
            default: glyph = 7'h71;
        endcase
    endfunction

    assign tc   = en && (cnt == CNT_LAST);
    assign wrap = tc && (idx == IDX_LAST);

    always_comb begin
        nib = disp_val[{idx, 2'b00} +: 4];
        // A digit is blank when it and every more-significant nibble are zero.
        blank_vec = '0;
        for (int k = 1; k < DIGITS; k++) begin
            blank_vec[k] = disp_blz && ((disp_val >> (4 * k)) == '0);
        end
        an_on  = '0;
        seg_on = '0;
        dp_on  = 1'b0;
        if (en) begin
            an_on[idx] = 1'b1;
            seg_on     = blank_vec[idx] ? 7'h00 : glyph(nib);
            dp_on      = disp_dp[idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            disp_val   <= '0;
            disp_dp    <= '0;
            disp_blz   <= 1'b0;
            pend_val   <= '0;
            pend_dp    <= '0;
            pend_blz   <= 1'b0;
            pend_valid <= 1'b0;
            wrap_q     <= 1'b0;
            frame_done <= 1'b0;
            seg        <= SEG_OFF;
            seg_dp     <= DP_OFF;
            an         <= AN_OFF;
        end else begin
            if (en) begin
                if (tc) begin
                    cnt <= '0;
                    idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end

            // Transfer happens before a same-edge load refills the pending buffer.
            if (wrap && pend_valid) begin
                disp_val   <= pend_val;
                disp_dp    <= pend_dp;
                disp_blz   <= pend_blz;
                pend_valid <= 1'b0;
            end
            if (load) begin
                pend_val   <= value;
                pend_dp    <= dp_in;
                pend_blz   <= blank_lz;
                pend_valid <= 1'b1;
            end

            // Delayed twice so the pulse lines up with digit 0 of the new frame.
            wrap_q     <= wrap;
            frame_done <= wrap_q;
            seg        <= SEG_ACTIVE_LOW ? ~seg_on : seg_on;
            seg_dp     <= SEG_ACTIVE_LOW ? ~dp_on : dp_on;
            an         <= AN_ACTIVE_LOW ? ~an_on : an_on;
        end
    end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed driver for a common-anode/common-cathode bank of `DIGITS` seven-segment digits.
- Scans one digit per `CLK_DIV` clock periods, decodes each 4-bit nibble to the standard hex glyph set 0–F, and adds per-digit decimal points and optional leading-zero blanking.
- Buffers new display values so a frame never shows a torn mix of old and new digits.
- Sits between datapath/status logic and the board's segment/anode pins, replacing the per-digit combinational decoder.

## Interface
Parameters:
- `DIGITS`, default 4: number of digits, legal range 1–8.
- `CLK_DIV`, default 50000: clock periods each digit stays lit, ≥1.
- `SEG_ACTIVE_LOW`, default 1: 1 means segment and dp outputs are inverted (lit = 0).
- `AN_ACTIVE_LOW`, default 1: 1 means anode enables are inverted (selected = 0).

Ports (one clock; reset is asynchronous and active-high):
- `clk` input 1: system clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `en` input 1: scan enable. When 0, all anodes are inactive and the prescaler and index hold.
- `load` input 1: single-cycle strobe that captures `value`, `dp_in` and `blank_lz`.
- `value` input 4*DIGITS: nibble k (bits 4k+3:4k) is digit k. Digit 0 is least significant and rightmost.
- `dp_in` input DIGITS: decimal point request per digit.
- `blank_lz` input 1: leading-zero blanking request, captured with `load`.
- `seg` output 7: segments {g,f,e,d,c,b,a}; bit0 = a.
- `seg_dp` output 1: decimal-point segment.
- `an` output DIGITS: one-hot digit enable.
- `frame_done` output 1: one-cycle pulse when the scan wraps from digit DIGITS-1 to digit 0.

## Operation
- **Pending buffer.** `load` writes `value`, `dp_in` and `blank_lz` into a pending buffer and sets `pend_valid`. If several loads arrive within one frame, the last one wins.
- **Display register.** The display register copies the pending buffer only on the wrap edge (index DIGITS-1 → 0), and only when `pend_valid` = 1. That edge clears `pend_valid`.
  - If `load` arrives on the wrap edge itself, the old pending contents transfer to the display register, the new data goes into pending, and `pend_valid` stays 1.
- **Prescaler.** Counts 0..CLK_DIV-1 while `en` = 1. At terminal count it returns to 0 and the digit index increments modulo DIGITS. With CLK_DIV = 1 the index advances every cycle. With DIGITS = 1 the index stays 0, and a wrap (with `frame_done`) occurs every CLK_DIV cycles.
- **Decode.** Active-high glyphs for 0–F are 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F, 77, 7C, 39, 5E, 79, 71 (hex), giving 0–9, A, b, C, d, E, F.
- **Leading-zero blanking.** When blanking is enabled, digit k > 0 is blank if every display nibble at positions ≥ k is 0.
  - Digit 0 is never blanked.
  - A blank digit drives all seven segments off, but its dp still follows `dp_in`.
- **Output polarity.** With SEG_ACTIVE_LOW, `seg` and `seg_dp` are inverted; with AN_ACTIVE_LOW, `an` is inverted. Unselected anodes are always inactive.
- **Disable.** When `en` = 0, `an` is all inactive and `seg`/`seg_dp` are off. Loads and transfers still behave as specified. Wraps do not occur, because the index holds.

## Timing
- All outputs are registered and computed from the current index and display register, so they lag an index change by 1 cycle.
- Reset values:
  - Prescaler, index, display register, pending buffer and `pend_valid` = 0.
  - `an` all inactive, `seg` and `seg_dp` off (polarity applied), `frame_done` = 0.
- First cycle after `rst` falls, with `en` = 1: `an` selects digit 0, showing glyph 3F (value 0).
- Index advance happens on the edge where prescaler = CLK_DIV-1. The new `an`/`seg` appear on the following edge.
- `frame_done` goes high for exactly the cycle after the wrap edge. New display data is visible on digit 0 in that same cycle.
- Latency from `load` to visible: at most one frame (DIGITS·CLK_DIV cycles) plus 1.
- `rst` asserted mid-scan: all outputs go to reset values immediately (asynchronous), and pending data is discarded.

## Test plan
DIGITS = 4, CLK_DIV = 4, both polarities active-low.
1. **Reset release.** Release `rst` with `en` = 1 → `an` = 1110 and `seg` = ~3F, and `an` steps 1101, 1011, 0111 every 4 cycles. `frame_done` pulses once per 16 cycles.
2. **Full glyph set.** Load `value` = 0xF1A5 → per digit, `seg` = ~6D (digit 0), ~77 (digit 1), ~06 (digit 2), ~71 (digit 3), starting from the frame after the next wrap.
3. **Leading-zero blanking.** Load `value` = 0x0030 with `blank_lz` = 1 and `dp_in` = 1000 → digit 3 `seg` = 7F (all off) with `seg_dp` = 0 (lit); digit 2 all off; digit 1 = ~4F; digit 0 = ~3F.
4. **Tear-free update.** Load 0x1111 mid-frame, then 0x2222 two cycles later → no 1111 frame is ever shown; 2222 appears on digit 0 in the `frame_done` cycle. Also load 0x3333 exactly on a wrap edge → the frame shows the old pending value, and 3333 appears in the next frame.
5. **Enable hold.** Drop `en` for 10 cycles mid-digit → `an` = 1111 during the gap; on resume the same digit continues with its remaining prescaler count, and no `frame_done` occurs during the gap.
6. **Asynchronous reset mid-operation.** Assert `rst` between clock edges mid-frame → `an` = 1111 and `seg` = 7F immediately; after release the display shows 0000, not the previously loaded data.
